// File: rtl/alu_sweep_master.sv
// alu_sweep_master: BIST initiator that sweeps all 8 ALU ops over 256 operand pairs and checks results.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, abort          begin a sweep (IDLE/DONE only), terminate a running sweep
//   result_in[3:0]        result nibble from the ALU responder
//   op_a, op_b, op_code   registered vector driven toward the ALU (op_code[3] always 0)
//   busy, done, pass      sweep status
//   err_count[7:0]        saturating mismatch count
//   fail_valid, fail_vec[10:0], fail_got[3:0]  first-failure record {op,a,b} and observed result
module alu_sweep_master #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  result_in,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  output logic [3:0]  op_code,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic        fail_valid,
  output logic [10:0] fail_vec,
  output logic [3:0]  fail_got
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [10:0] idx_q, idx_d, fail_vec_q, fail_vec_d;
  logic [3:0] cnt_q, cnt_d, op_a_q, op_a_d, op_b_q, op_b_d, op_code_q, op_code_d, fail_got_q, fail_got_d;
  logic [7:0] err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_valid_q, fail_valid_d;
  logic [3:0] expected;
  always_comb begin
    expected = 4'h0;
    case (op_code_q[2:0])
      3'd0: expected = op_a_q + op_b_q;
      3'd1: expected = op_a_q - op_b_q;
      3'd2: expected = op_a_q & op_b_q;
      3'd3: expected = op_a_q | op_b_q;
      3'd4: expected = (op_a_q == op_b_q) ? 4'hF : 4'h0;
      3'd5: expected = ~op_a_q;
      3'd6: expected = (op_a_q > op_b_q) ? 4'hF : 4'h0;
      default: expected = (op_a_q < op_b_q) ? 4'hF : 4'h0;
    endcase
  end
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_got_d   = fail_got_q;
    // abort pre-empts everything, including the CHECK comparison of the current vector
    if (abort && busy_q) state_d = IDLE;
    else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d      = DRIVE;
          idx_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          fail_got_d   = '0;
        end
        DRIVE: begin
          op_code_d = {1'b0, idx_q[10:8]};
          op_a_d    = idx_q[7:4];
          op_b_d    = idx_q[3:0];
          cnt_d     = 4'(SETTLE_CYCLES - 1);
          state_d   = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
        end
        SETTLE: begin
          state_d = (cnt_q == 4'd0) ? CHECK : SETTLE;
          cnt_d   = cnt_q - 4'd1;
        end
        CHECK: begin
          if (result_in != expected) begin
            err_d = err_q + 8'(err_q != 8'hFF);
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = {op_code_q[2:0], op_a_q, op_b_q};
              fail_got_d   = result_in;
            end
          end
          state_d = (idx_q == 11'h7FF) ? DONE : DRIVE;
          idx_d   = idx_q + 11'd1;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == CHECK);
    done_d = state_d == DONE;
    pass_d = done_d && (err_d == 8'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_got_q   <= fail_got_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_code    = op_code_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_got   = fail_got_q;
endmodule

// File: tb/tb_alu_sweep_master.sv
// tb_alu_sweep_master: directed bench for alu_sweep_master with golden, faulty and stuck responders.
module tb_alu_sweep_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0;
  logic [3:0] result_in, result0;
  logic [3:0] op_a, op_b, op_code, op_a0, op_b0, op_code0;
  logic busy, done, pass, busy0, done0, pass0;
  logic [7:0] err_count, err_count0;
  logic fail_valid, fail_valid0;
  logic [10:0] fail_vec, fail_vec0;
  logic [3:0] fail_got, fail_got0;
  int mode = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return (a == b) ? 4'hF : 4'h0;
      3'd5: return ~a;
      3'd6: return (a > b) ? 4'hF : 4'h0;
      default: return (a < b) ? 4'hF : 4'h0;
    endcase
  endfunction
  assign result_in = (mode == 2) ? 4'h0 :
                     (mode == 1 && op_code == 4'd3) ? (op_a & op_b) : model(op_code[2:0], op_a, op_b);
  assign result0 = model(op_code0[2:0], op_a0, op_b0);
  alu_sweep_master #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .result_in(result_in),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_got(fail_got)
  );
  alu_sweep_master #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .result_in(result0),
    .op_a(op_a0), .op_b(op_b0), .op_code(op_code0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err_count0), .fail_valid(fail_valid0), .fail_vec(fail_vec0), .fail_got(fail_got0)
  );
  wire [39:0] outs  = {op_a, op_b, op_code, busy, done, pass, err_count, fail_valid, fail_vec, fail_got};
  wire [39:0] outs0 = {op_a0, op_b0, op_code0, busy0, done0, pass0, err_count0, fail_valid0, fail_vec0, fail_got0};
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic pulse_start0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (outs !== 40'd0) begin errors++; $display("FAIL reset_outs got=%h exp=0", outs); end
    checks++; if (outs0 !== 40'd0) begin errors++; $display("FAIL reset_outs0 got=%h exp=0", outs0); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (outs !== 40'd0) begin errors++; $display("FAIL idle_outs got=%h exp=0", outs); end
    checks++; if (outs0 !== 40'd0) begin errors++; $display("FAIL idle_outs0 got=%h exp=0", outs0); end
  endtask
  task automatic test_golden();
    mode = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL golden_busy got=%b exp=1", busy); end
    repeat (8191) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL golden_done_early got=%b exp=0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL golden_done got=%b exp=1", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL golden_pass got=%b exp=1", pass); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL golden_busy_end got=%b exp=0", busy); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL golden_err got=%0d exp=0", err_count); end
    checks++; if (fail_valid !== 1'b0) begin errors++; $display("FAIL golden_fv got=%b exp=0", fail_valid); end
  endtask
  task automatic test_faulty_or();
    bit ok;
    mode = 1;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL faulty_timeout got=0 exp=done"); end
    checks++; if (err_count !== 8'd240) begin errors++; $display("FAIL faulty_err got=%0d exp=240", err_count); end
    checks++; if (fail_vec !== {3'd3, 4'd0, 4'd1}) begin errors++; $display("FAIL faulty_vec got=%h exp=301", fail_vec); end
    checks++; if (fail_got !== 4'd0) begin errors++; $display("FAIL faulty_got got=%h exp=0", fail_got); end
    checks++; if (fail_valid !== 1'b1) begin errors++; $display("FAIL faulty_fv got=%b exp=1", fail_valid); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL faulty_pass got=%b exp=0", pass); end
  endtask
  task automatic test_stuck_zero();
    bit ok;
    mode = 2;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stuck_timeout got=0 exp=done"); end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL stuck_err got=%0d exp=255", err_count); end
    checks++; if (fail_vec !== {3'd0, 4'd0, 4'd1}) begin errors++; $display("FAIL stuck_vec got=%h exp=001", fail_vec); end
    checks++; if (fail_got !== 4'd0) begin errors++; $display("FAIL stuck_got got=%h exp=0", fail_got); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got=%b exp=0", pass); end
  endtask
  task automatic test_abort();
    bit ok;
    mode = 2;
    pulse_start();
    repeat (99) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (err_count !== 8'd23) begin errors++; $display("FAIL abort_err got=%0d exp=23", err_count); end
    checks++; if (fail_vec !== {3'd0, 4'd0, 4'd1}) begin errors++; $display("FAIL abort_vec got=%h exp=001", fail_vec); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got=%b exp=0", busy); end
    mode = 0;
    pulse_start();
    checks++; if ({busy, err_count, fail_valid} !== {1'b1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL restart_clear got=%b/%0d/%b exp=1/0/0", busy, err_count, fail_valid);
    end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got=0 exp=done"); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL restart_pass got=%b exp=1", pass); end
  endtask
  task automatic test_settle0();
    pulse_start0();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL s0_busy got=%b exp=1", busy0); end
    repeat (49) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (4045) @(negedge clk);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL s0_done_early got=%b exp=0", done0); end
    @(negedge clk);
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL s0_done got=%b exp=1", done0); end
    checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL s0_pass got=%b exp=1", pass0); end
  endtask
  task automatic test_reset_mid();
    pulse_start0();
    repeat (30) @(negedge clk);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs0 !== 40'd0) begin errors++; $display("FAIL mid_reset0 got=%h exp=0", outs0); end
    checks++; if (outs !== 40'd0) begin errors++; $display("FAIL mid_reset got=%h exp=0", outs); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++; if (outs0 !== 40'd0) begin errors++; $display("FAIL post_reset0 got=%h exp=0", outs0); end
  endtask
  initial begin
    test_reset();
    test_golden();
    test_faulty_or();
    test_stuck_zero();
    test_abort();
    test_settle0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sweep_master.md
# alu_sweep_master

Self-checking initiator for the 4-bit ALU chip interface. It drives operand A, operand B and the 4-bit opcode toward an ALU responder and waits a programmable settle time. It then samples the returned 4-bit result and compares it against an internal reference model, sweeping every defined operation over all 256 operand pairs. The block sits on the driving side of the ALU interface as on-chip built-in self test: it produces the switch and opcode inputs and consumes the result nibble.

## Interface
- `SETTLE_CYCLES`, default 2: idle cycles between driving a vector and sampling its result. Legal range 0–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assertion, active-low.
- `start`  in  1  begin a sweep. Sampled only in IDLE or DONE.
- `abort`  in  1  terminate a running sweep.
- `result_in`  in  4  result nibble returned by the ALU responder.
- `op_a`  out  4  operand A (switch high nibble).
- `op_b`  out  4  operand B (switch low nibble).
- `op_code`  out  4  ALU opcode; always 0–7, so bit 3 is always 0.
- `busy`  out  1  high while the sweep is running.
- `done`  out  1  high in DONE until the next start.
- `pass`  out  1  `done && err_count == 0`.
- `err_count`  out  8  mismatch count, saturating at 255.
- `fail_valid`  out  1  a first-failure record has been captured.
- `fail_vec`  out  11  `{op, a, b}` of the first mismatching vector.
- `fail_got`  out  4  `result_in` value at the first mismatch.

## Operation
- 11-bit vector index `idx`, mapped as `op = idx[10:8]`, `a = idx[7:4]`, `b = idx[3:0]`. The sweep runs `idx` from 0 to 2047 in order.
- Reference model (4-bit, modulo 16):
  - 0 ADD: `a+b`.
  - 1 SUB: `a-b`.
  - 2 AND: `a&b`.
  - 3 OR: `a|b`.
  - 4 EQ: `F` if `a==b`, else `0`.
  - 5 NOT: `~a`.
  - 6 GT: `F` if `a>b`, else `0`.
  - 7 LT: `F` if `a<b`, else `0`.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE: `start` → DRIVE. This clears `idx`, `err_count`, `fail_valid`, `fail_vec` and `fail_got`.
  - DRIVE: registers `op_a`, `op_b` and `op_code` from `idx`. Goes to SETTLE, or directly to CHECK if `SETTLE_CYCLES == 0`.
  - SETTLE: counts `SETTLE_CYCLES` cycles, then goes to CHECK.
  - CHECK: compares `result_in` to the model.
    - On mismatch: increment `err_count` unless it is 255. If `fail_valid` is 0, capture `fail_vec` and `fail_got` and set `fail_valid`.
    - If `idx == 2047`: go to DONE. Otherwise increment `idx` and go to DRIVE.
  - DONE: holds all results. `start` restarts exactly as from IDLE.
- `abort` in DRIVE, SETTLE or CHECK → IDLE on the next edge. `done` stays 0. Result registers keep their partial values.
- `abort` has priority over the CHECK comparison in the same cycle: that vector is not counted.
- `start` while `busy` is ignored. `start` and `abort` both high in IDLE/DONE: `start` wins (abort is meaningless there).
- `busy` is 1 in DRIVE, SETTLE and CHECK.

## Timing
- Reset values: all outputs 0 and state IDLE. `rst_n` low mid-sweep clears everything immediately, without waiting for a clock edge.
- `start` sampled at edge k → `busy` is 1 after edge k. First vector outputs are valid after edge k+1.
- Vector outputs are stable for `SETTLE_CYCLES`+1 cycles before the CHECK edge samples `result_in`. The responder must be combinational or settle within that window.
- Per vector: `SETTLE_CYCLES`+2 cycles. Full sweep: `2048*(SETTLE_CYCLES+2)` cycles.
  - With default 2: `done` is high after edge k+8192.
- `done`, `pass` and `busy` change on the same edge the state enters or leaves DONE.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0. Release, idle 10 cycles → outputs unchanged.
- Golden responder, `SETTLE_CYCLES`=2: pulse `start` → `busy` next cycle. `done`=1, `pass`=1, `err_count`=0 and `fail_valid`=0 exactly 8192 cycles after `start`.
- Faulty responder that returns `a&b` for op 3: expect `err_count`=240, `fail_vec`=`{3'd3,4'd0,4'd1}`, `fail_got`=0, `pass`=0.
- Responder stuck at 0: `err_count` saturates at 255. `fail_vec`=`{3'd0,4'd0,4'd1}`, `fail_got`=0.
- Assert `abort` 100 cycles into the sweep → IDLE next edge, `busy`=0, `done`=0. `start` again → counters cleared and the full sweep completes with `pass`=1.
- With `SETTLE_CYCLES`=0: `done` after 4096 cycles. `start` pulses while `busy` are ignored. `rst_n` low mid-sweep clears all outputs without a clock edge.
